// File: rtl/mux41_arb_pkg.sv
// Shared constants and types for the 4-way round-robin mux arbiter.
// Pure declarations; no logic, no latency.
package mux41_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// Requester-side bundle of the arbiter: level requests and data lanes in, grant/select/data out.
// Requesters hold req high until done; the grant is the only backpressure.
interface mux41_rr_arbiter_if import mux41_arb_pkg::*; #(parameter int DATA_W = 1);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] c;
    logic [N_REQ-1:0]        gnt;
    logic [SEL_W-1:0]        sel;
    logic [DATA_W-1:0]       z;
    logic                    z_valid;

    modport master (output req, c, input gnt, sel, z, z_valid);
    modport slave  (input req, c, output gnt, sel, z, z_valid);
endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set req bit at ptr, ptr+1, ... wrapping 3->0.
// Zero latency; found=0 when no request is set.
module rr_pick4 import mux41_arb_pkg::*; (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [SEL_W-1:0] cand;

    // Scan farthest-first so the candidate nearest the pointer overwrites the rest.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin owner of the 4:1 mux select; grant/sel 1 clk after req, z one clk behind grant.
// Tenure capped at MAX_HOLD cycles only while another requester waits; handoff has no bubble.
module mux41_rr_arbiter import mux41_arb_pkg::*; #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux41_rr_arbiter_if.slave bus
);
    localparam int HC_W = $clog2(MAX_HOLD + 1);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] z_q, z_d;
    logic              z_valid_q, z_valid_d;

    logic [DATA_W-1:0] lane_dat;
    logic              others_pend;
    logic              expired;
    logic              owner_rel;
    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;

    assign lane_dat    = bus.c[int'(sel_q)*DATA_W +: DATA_W];
    assign others_pend = |(bus.req & ~onehot(sel_q));
    assign expired     = (hold_cnt_q == HC_W'(MAX_HOLD));
    assign owner_rel   = (state_q == GRANT) && (!bus.req[sel_q] || (expired && others_pend));
    // A releasing owner hands the search start to its successor in the same cycle.
    assign pick_ptr    = owner_rel ? sel_q + SEL_W'(1) : rr_ptr_q;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        z_d        = z_q;
        z_valid_d  = z_valid_q;
        case (state_q)
            IDLE: begin
                z_d       = '0;
                z_valid_d = 1'b0;
                gnt_d     = '0;
                sel_d     = '0;
                if (pick_found) begin
                    state_d    = GRANT;
                    gnt_d      = onehot(pick_idx);
                    sel_d      = pick_idx;
                    hold_cnt_d = HC_W'(1);
                end
            end
            GRANT: begin
                z_d       = lane_dat;
                z_valid_d = 1'b1;
                if (owner_rel) begin
                    rr_ptr_d = pick_ptr;
                    if (pick_found) begin
                        gnt_d      = onehot(pick_idx);
                        sel_d      = pick_idx;
                        hold_cnt_d = HC_W'(1);
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        sel_d     = '0;
                        z_d       = '0;
                        z_valid_d = 1'b0;
                    end
                end else if (!expired) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            sel_q      <= '0;
            z_q        <= '0;
            z_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            z_q        <= z_d;
            z_valid_q  <= z_valid_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.z       = z_q;
    assign bus.z_valid = z_valid_q;
endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Bench for mux41_rr_arbiter: vector table, directed corner sequences and a random run
// compared against an owner/pointer/tenure reference model.
module tb_mux41_rr_arbiter;
    import mux41_arb_pkg::*;

    localparam int DW = 1;
    localparam int MH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux41_rr_arbiter_if #(.DATA_W(DW)) bus();

    mux41_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the mux, where the search starts, how long the owner has held it.
    int            m_owner;
    int            m_ptr;
    int            m_hold;
    logic [DW-1:0] m_z;
    logic          m_zv;

    typedef struct {
        logic [3:0]      req;
        logic [4*DW-1:0] c;
        logic [3:0]      gnt;
        logic [1:0]      sel;
        logic [DW-1:0]   z;
        logic            zv;
    } vec_t;

    vec_t tv[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_z     = '0;
        m_zv    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [4*DW-1:0] cc);
        int            nxt;
        logic [DW-1:0] lane;
        logic          others;
        if (m_owner < 0) begin
            m_z  = '0;
            m_zv = 1'b0;
            nxt  = pick(r, m_ptr);
            if (nxt >= 0) begin
                m_owner = nxt;
                m_hold  = 1;
            end
        end else begin
            lane   = cc[m_owner*DW +: DW];
            others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            if (!r[m_owner] || (m_hold == MH && others)) begin
                m_ptr = (m_owner + 1) % 4;
                nxt   = pick(r, m_ptr);
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_hold  = 1;
                    m_z     = lane;
                    m_zv    = 1'b1;
                end else begin
                    m_owner = -1;
                    m_z     = '0;
                    m_zv    = 1'b0;
                end
            end else begin
                if (m_hold < MH) m_hold++;
                m_z  = lane;
                m_zv = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        logic [1:0] es;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        es = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
        check({tag, "_sel"}, 32'(bus.sel), 32'(es));
        check({tag, "_z"}, 32'(bus.z), 32'(m_z));
        check({tag, "_zv"}, 32'(bus.z_valid), 32'(m_zv));
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input logic [3:0] r, input logic [4*DW-1:0] cc);
        bus.req = r;
        bus.c   = cc;
        model_step(r, cc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        bus.c   = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]      r;
        logic [4*DW-1:0] cc;

        //          req      c        gnt      sel   z     zv
        tv[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
        tv[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tv[2]  = '{4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
        tv[3]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0};
        tv[4]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1};
        tv[5]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tv[6]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b1};
        tv[7]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        tv[8]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tv[9]  = '{4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b0, 1'b0};
        tv[10] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};

        bus.req = 4'hF;
        bus.c   = 4'hF;
        model_reset();

        // Reset held with every lane requesting.
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_sel", 32'(bus.sel), 32'h0);
        check("rst_z", 32'(bus.z), 32'h0);
        check("rst_zv", 32'(bus.z_valid), 32'h0);
        rst_n = 1'b1;
        cycle(4'hF, 4'hF);
        check("rst_first_gnt", 32'(bus.gnt), 32'h1);

        // Single request, drop, and pointer wrap through the vector table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cycle(tv[i].req, tv[i].c);
            check($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(tv[i].gnt));
            check($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(tv[i].sel));
            check($sformatf("vec%0d_z", i), 32'(bus.z), 32'(tv[i].z));
            check($sformatf("vec%0d_zv", i), 32'(bus.z_valid), 32'(tv[i].zv));
        end

        // All requesting: each lane owns exactly MH cycles, in order, no idle gap.
        do_reset();
        for (int k = 0; k < 5 * MH; k++) begin
            cycle(4'hF, 4'($urandom));
            check("rr_turn", 32'(bus.gnt), 32'(4'b0001 << ((k / MH) % 4)));
            check_model("rr");
        end

        // Solo holder keeps the grant past MH, then yields at once when a rival appears.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(4'b1000, 4'($urandom));
            check("solo_gnt", 32'(bus.gnt), 32'h8);
        end
        cycle(4'b1001, 4'($urandom));
        check("solo_expiry_gnt", 32'(bus.gnt), 32'h1);
        check_model("solo");

        // Asynchronous reset in the middle of a lane-1 tenure.
        do_reset();
        repeat (3) cycle(4'b0010, 4'b0010);
        check("mid_gnt_before", 32'(bus.gnt), 32'h2);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(bus.gnt), 32'h0);
        check("arst_zv", 32'(bus.z_valid), 32'h0);
        check("arst_sel", 32'(bus.sel), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(4'hF, 4'($urandom));
        check("arst_restart_gnt", 32'(bus.gnt), 32'h1);

        // Random level requests with sticky bits so tenures and expiries both occur.
        do_reset();
        r = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            end
            cc = 4'($urandom);
            cycle(r, cc);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
